// File: rtl/imem_pkg.sv
// Shared constants for the pipelined instruction memory:
// fault bit positions, fault vector width and the bubble fill value.
package imem_pkg;

   localparam int FAULT_W        = 2;
   localparam int FAULT_MISALIGN = 0;
   localparam int FAULT_RANGE    = 1;

   // Bubble instruction is every bit set to this value, whatever DATA_W is.
   localparam logic RESET_INSTR_FILL = 1'b1;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read port, one write port.
// A same-edge read of the written word returns the old contents.
module imem_array
   import imem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk_i,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-3:0] wr_idx,
   input  logic [DATA_W-1:0] wr_data
);

   localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   // Both ports in one block so the read samples the pre-write value.
   always_ff @(posedge clk_i) begin
      if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
      if (wr_en && (wr_idx < DEPTH_IDX)) begin
         mem[wr_idx[IDX_W-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/pipelined_instruction_memory.sv
// Instruction memory for the fetch stage: valid/ready request port, LATENCY-deep
// result pipeline with stall/flush, alignment/range faults and a side load port.
module pipelined_instruction_memory
   import imem_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter int                DEPTH       = 1024,
   parameter int                LATENCY     = 1,
   parameter logic [DATA_W-1:0] RESET_INSTR = {DATA_W{RESET_INSTR_FILL}}
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic                stall_i,
   input  logic                flush_i,
   output logic [DATA_W-1:0]   instr_o,
   output logic                instr_valid_o,
   output logic [FAULT_W-1:0]  fault_o,
   input  logic                load_en_i,
   input  logic [ADDR_W-1:0]   load_addr_i,
   input  logic [DATA_W-1:0]   load_data_i
);

   localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);

   logic               accept;
   logic               advance;
   logic [FAULT_W-1:0] req_fault;
   logic [DATA_W-1:0]  rd_data;
   logic               valid_s1;
   logic [FAULT_W-1:0] fault_s1;
   logic               out_valid;
   logic [FAULT_W-1:0] out_fault;
   logic [DATA_W-1:0]  out_data;
   logic               load_lsb_unused;

   assign req_ready_o = !rst_i && !stall_i;
   assign accept      = req_valid_i && req_ready_o;
   // Flush must clear stages even while the hazard unit holds stall.
   assign advance     = flush_i || !stall_i;

   always_comb begin
      req_fault                 = '0;
      req_fault[FAULT_MISALIGN] = (addr_i[1:0] != 2'b00);
      req_fault[FAULT_RANGE]    = (addr_i[ADDR_W-1:2] >= DEPTH_IDX);
   end

   // Load addresses are word-granular.
   assign load_lsb_unused = ^load_addr_i[1:0];

   imem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .rd_en   (accept && (req_fault == '0)),
      .rd_idx  (addr_i[IDX_W+1:2]),
      .rd_data (rd_data),
      .wr_en   (load_en_i && !rst_i),
      .wr_idx  (load_addr_i[ADDR_W-1:2]),
      .wr_data (load_data_i)
   );

   // s1 data is the array's read register; only valid/fault live here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_s1 <= 1'b0;
         fault_s1 <= '0;
      end else if (advance) begin
         valid_s1 <= accept;
         fault_s1 <= accept ? req_fault : '0;
      end
   end

   if (LATENCY == 1) begin : g_single
      assign out_valid = valid_s1;
      assign out_fault = fault_s1;
      assign out_data  = rd_data;
   end else begin : g_multi
      logic               tail_valid [LATENCY-1];
      logic [FAULT_W-1:0] tail_fault [LATENCY-1];
      logic [DATA_W-1:0]  tail_data  [LATENCY-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            for (int i = 0; i < LATENCY-1; i++) begin
               tail_valid[i] <= 1'b0;
               tail_fault[i] <= '0;
            end
         end else if (advance) begin
            tail_valid[0] <= flush_i ? 1'b0 : valid_s1;
            tail_fault[0] <= flush_i ? '0 : fault_s1;
            for (int i = 1; i < LATENCY-1; i++) begin
               tail_valid[i] <= flush_i ? 1'b0 : tail_valid[i-1];
               tail_fault[i] <= flush_i ? '0 : tail_fault[i-1];
            end
         end
      end

      // Payload needs no reset; it is masked whenever its valid bit is low.
      always_ff @(posedge clk_i) begin
         if (advance) begin
            tail_data[0] <= rd_data;
            for (int i = 1; i < LATENCY-1; i++) begin
               tail_data[i] <= tail_data[i-1];
            end
         end
      end

      assign out_valid = tail_valid[LATENCY-2];
      assign out_fault = tail_fault[LATENCY-2];
      assign out_data  = tail_data[LATENCY-2];
   end

   assign instr_valid_o = out_valid;
   assign fault_o       = out_valid ? out_fault : '0;
   assign instr_o       = (out_valid && (out_fault == '0)) ? out_data : RESET_INSTR;

endmodule

// File: tb/tb_pipelined_instruction_memory.sv
// Directed bench: three instances (LATENCY 1, 2, 3) share the same stimulus,
// each checked at its own result timing.
module tb_pipelined_instruction_memory;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic [31:0] addr_i;
   logic        stall_i;
   logic        flush_i;
   logic        load_en_i;
   logic [31:0] load_addr_i;
   logic [31:0] load_data_i;

   logic        rdy1, rdy2, rdy3;
   logic [31:0] ins1, ins2, ins3;
   logic        val1, val2, val3;
   logic [1:0]  flt1, flt2, flt3;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   pipelined_instruction_memory #(.LATENCY(1)) u_l1 (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(rdy1),
      .addr_i(addr_i), .stall_i(stall_i), .flush_i(flush_i), .instr_o(ins1),
      .instr_valid_o(val1), .fault_o(flt1), .load_en_i(load_en_i),
      .load_addr_i(load_addr_i), .load_data_i(load_data_i));

   pipelined_instruction_memory #(.LATENCY(2)) u_l2 (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(rdy2),
      .addr_i(addr_i), .stall_i(stall_i), .flush_i(flush_i), .instr_o(ins2),
      .instr_valid_o(val2), .fault_o(flt2), .load_en_i(load_en_i),
      .load_addr_i(load_addr_i), .load_data_i(load_data_i));

   pipelined_instruction_memory #(.LATENCY(3)) u_l3 (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(rdy3),
      .addr_i(addr_i), .stall_i(stall_i), .flush_i(flush_i), .instr_o(ins3),
      .instr_valid_o(val3), .fault_o(flt3), .load_en_i(load_en_i),
      .load_addr_i(load_addr_i), .load_data_i(load_data_i));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i       = 1'b0;
      req_valid_i = 1'b0;
      addr_i      = '0;
      stall_i     = 1'b0;
      flush_i     = 1'b0;
      load_en_i   = 1'b0;
      load_addr_i = '0;
      load_data_i = '0;

      // Asynchronous reset mid-cycle
      #3 rst_i = 1'b1;
      #1;
      chk("rst_instr1", ins1, 32'hFFFF_FFFF);
      chk("rst_instr3", ins3, 32'hFFFF_FFFF);
      chk("rst_valid1", {31'b0, val1}, 32'd0);
      chk("rst_valid2", {31'b0, val2}, 32'd0);
      chk("rst_fault3", {30'b0, flt3}, 32'd0);
      chk("rst_ready1", {31'b0, rdy1}, 32'd0);
      chk("rst_ready3", {31'b0, rdy3}, 32'd0);
      step();
      step();
      rst_i = 1'b0;
      #1;
      chk("ready_after_rst", {31'b0, rdy2}, 32'd1);

      // Program memory
      load_en_i = 1'b1; load_addr_i = 32'h0; load_data_i = 32'h1111_1111;
      step();
      load_addr_i = 32'h4; load_data_i = 32'h2222_2222;
      step();
      load_addr_i = 32'h8; load_data_i = 32'hABCD_0000;
      step();
      load_en_i = 1'b0;

      // Back-to-back requests
      req_valid_i = 1'b1; addr_i = 32'h0;
      step();
      chk("b2b_l1_v0", {31'b0, val1}, 32'd1);
      chk("b2b_l1_d0", ins1, 32'h1111_1111);
      chk("b2b_l1_f0", {30'b0, flt1}, 32'd0);
      chk("b2b_l2_early", {31'b0, val2}, 32'd0);
      addr_i = 32'h4;
      step();
      chk("b2b_l1_d1", ins1, 32'h2222_2222);
      chk("b2b_l2_v0", {31'b0, val2}, 32'd1);
      chk("b2b_l2_d0", ins2, 32'h1111_1111);
      chk("b2b_l2_f0", {30'b0, flt2}, 32'd0);
      req_valid_i = 1'b0;
      step();
      chk("b2b_l1_bubble_v", {31'b0, val1}, 32'd0);
      chk("b2b_l1_bubble_d", ins1, 32'hFFFF_FFFF);
      chk("b2b_l2_d1", ins2, 32'h2222_2222);
      chk("b2b_l3_d0", ins3, 32'h1111_1111);
      step();
      chk("b2b_l2_end", {31'b0, val2}, 32'd0);
      chk("b2b_l3_d1", ins3, 32'h2222_2222);
      step();
      chk("b2b_l3_end", {31'b0, val3}, 32'd0);

      // Faults
      req_valid_i = 1'b1; addr_i = 32'h6;
      step();
      chk("mis_valid", {31'b0, val1}, 32'd1);
      chk("mis_fault", {30'b0, flt1}, 32'd1);
      chk("mis_instr", ins1, 32'hFFFF_FFFF);
      addr_i = 32'hFFC;
      step();
      chk("last_word_fault", {30'b0, flt1}, 32'd0);
      addr_i = 32'h1000;
      step();
      chk("range_fault", {30'b0, flt1}, 32'd2);
      chk("range_instr", ins1, 32'hFFFF_FFFF);
      addr_i = 32'h1002;
      step();
      chk("both_fault", {30'b0, flt1}, 32'd3);
      req_valid_i = 1'b0;
      step();
      chk("both_fault_l2", {30'b0, flt2}, 32'd3);
      step();
      step();

      // Stall with two requests in flight
      req_valid_i = 1'b1; addr_i = 32'h0;
      step();
      addr_i = 32'h4;
      step();
      addr_i  = 32'h8;
      stall_i = 1'b1;
      #1;
      chk("stall_ready", {31'b0, rdy3}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_l1_hold", ins1, 32'h2222_2222);
         chk("stall_l2_hold", ins2, 32'h1111_1111);
         chk("stall_l3_hold", {31'b0, val3}, 32'd0);
      end
      stall_i = 1'b0; req_valid_i = 1'b0;
      step();
      chk("unstall_l1_bubble", {31'b0, val1}, 32'd0);
      chk("unstall_l2_d1", ins2, 32'h2222_2222);
      chk("unstall_l3_d0", ins3, 32'h1111_1111);
      step();
      chk("unstall_l3_d1", ins3, 32'h2222_2222);
      step();
      chk("unstall_l3_end", {31'b0, val3}, 32'd0);

      // Flush with redirect request in the flush cycle
      req_valid_i = 1'b1; addr_i = 32'h0;
      step();
      addr_i = 32'h4;
      step();
      flush_i = 1'b1; addr_i = 32'h8;
      step();
      chk("flush_l1_new", ins1, 32'hABCD_0000);
      chk("flush_l2_v", {31'b0, val2}, 32'd0);
      chk("flush_l3_v", {31'b0, val3}, 32'd0);
      chk("flush_l2_instr", ins2, 32'hFFFF_FFFF);
      flush_i = 1'b0; req_valid_i = 1'b0;
      step();
      chk("flush_l2_new", ins2, 32'hABCD_0000);
      chk("flush_l3_old_gone", {31'b0, val3}, 32'd0);
      step();
      chk("flush_l3_new_v", {31'b0, val3}, 32'd1);
      chk("flush_l3_new", ins3, 32'hABCD_0000);
      step();
      chk("flush_l3_end", {31'b0, val3}, 32'd0);

      // Flush overrides stall
      req_valid_i = 1'b1; addr_i = 32'h0;
      step();
      chk("fs_pre", ins1, 32'h1111_1111);
      req_valid_i = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
      step();
      chk("fs_l1_v", {31'b0, val1}, 32'd0);
      chk("fs_l1_instr", ins1, 32'hFFFF_FFFF);
      stall_i = 1'b0; flush_i = 1'b0;
      step();
      chk("fs_l2_v", {31'b0, val2}, 32'd0);

      // Read-before-write on the same word
      req_valid_i = 1'b1; addr_i = 32'h4;
      load_en_i = 1'b1; load_addr_i = 32'h4; load_data_i = 32'h3333_3333;
      step();
      chk("rbw_old", ins1, 32'h2222_2222);
      load_en_i = 1'b0;
      step();
      chk("rbw_new", ins1, 32'h3333_3333);
      req_valid_i = 1'b0;

      // Out-of-range load must not alias onto word 0
      load_en_i = 1'b1; load_addr_i = 32'h1000; load_data_i = 32'hDEAD_BEEF;
      step();
      load_en_i = 1'b0; req_valid_i = 1'b1; addr_i = 32'h0;
      step();
      chk("oor_load_ignored", ins1, 32'h1111_1111);
      req_valid_i = 1'b0;

      // Reset keeps memory contents
      #3 rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      req_valid_i = 1'b1; addr_i = 32'h8;
      step();
      chk("mem_kept_over_rst", ins1, 32'hABCD_0000);
      req_valid_i = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
